// File: rtl/alu_sequencer.sv
// Single-issue sequencer: accepts one data-processing op, evaluates its ARM
// condition against the owned NZCV register, drives the shared ALU and returns the result.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_opcode,
  input  logic        req_s,
  input  logic [3:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_carry,
  input  logic [31:0] alu_c,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_rd,
  output logic        rsp_we,
  output logic        rsp_executed,
  input  logic        flags_load,
  input  logic [3:0]  flags_load_data,
  output logic [3:0]  flags_q
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_next;
  logic [3:0]  cond_q, opcode_q, rd_q;
  logic        s_q;
  logic [31:0] a_q, b_q;
  logic        pass, executed, is_test, is_arith, flag_update;
  logic        n, z, c, v;

  assign n = flags_q[0];
  assign z = flags_q[1];
  assign c = flags_q[2];
  assign v = flags_q[3];

  assign alu_carry = flags_q[2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next = RESP;
        alu_a      = a_q;
        alu_b      = b_q;
        alu_opcode = opcode_q;
        if (opcode_q == 4'hD) begin
          alu_opcode = 4'h0;
          alu_b      = ~b_q;
        end else if (opcode_q == 4'hE) begin
          alu_opcode = 4'h1;
          alu_a      = 32'hFFFF_FFFF;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pass = 1'b0;
    unique case (cond_q)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = ~z & (n == v);
      4'hD: pass = z | (n != v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign executed    = pass & (opcode_q != 4'hF);
  assign is_test     = (opcode_q inside {4'h8, 4'h9, 4'hA, 4'hB});
  assign is_arith    = (opcode_q inside {[4'h2:4'h7], 4'hA, 4'hB});
  assign flag_update = (state == EXEC) & executed & (s_q | is_test);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q       <= '0;
      opcode_q     <= '0;
      s_q          <= 1'b0;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result   <= '0;
      rsp_rd       <= '0;
      rsp_we       <= 1'b0;
      rsp_executed <= 1'b0;
      flags_q      <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        cond_q   <= req_cond;
        opcode_q <= req_opcode;
        s_q      <= req_s;
        rd_q     <= req_rd;
        a_q      <= req_a;
        b_q      <= req_b;
      end
      if (state == EXEC) begin
        rsp_result   <= executed ? alu_c : '0;
        rsp_rd       <= rd_q;
        rsp_we       <= executed & ~is_test;
        rsp_executed <= executed;
      end
      // An MSR write takes priority over the flag update of the op in flight.
      if (flags_load)
        flags_q <= flags_load_data;
      else if (flag_update)
        flags_q <= is_arith ? alu_flags : {flags_q[3:2], alu_flags[1:0]};
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Single-issue controller that sequences data-processing operations through the shared combinational ALU. It accepts one operation at a time over a valid/ready request port and evaluates the ARM condition field against the architectural NZCV register it owns. It drives the ALU, with operand pre-conditioning for BIC and MVN, updates flags per ARM rules, and returns the result over a valid/ready response port. It sits between decode/register-read and register writeback.

## Interface
Parameters: none (data width fixed at 32, register index fixed at 4).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request (1 iff state IDLE)
- req_cond  in  4  ARM condition field
- req_opcode  in  4  ALU opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D BIC, E MVN, F illegal
- req_s  in  1  set-flags bit
- req_rd  in  4  destination register index
- req_a, req_b  in  32  operands (Rn, shifted operand)
- alu_a, alu_b  out  32  ALU operands
- alu_opcode  out  4  ALU opcode
- alu_carry  out  1  ALU carry-in, always flags_q[2]
- alu_c  in  32  ALU result
- alu_flags  in  4  ALU flags, bit0 N, bit1 Z, bit2 C, bit3 V
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  result (0 when not executed)
- rsp_rd  out  4  captured req_rd
- rsp_we  out  1  register writeback required
- rsp_executed  out  1  condition passed and opcode legal
- flags_load  in  1  external NZCV write (MSR)
- flags_load_data  in  4  value for flags_load
- flags_q  out  4  architectural NZCV, same bit order as alu_flags

## Operation
- FSM states and transitions:
  - IDLE: req_valid&req_ready captures cond/opcode/s/rd/a/b and moves to EXEC.
  - EXEC: always one cycle, then moves to RESP.
  - RESP: rsp_valid=1; rsp_valid&rsp_ready moves to IDLE.
- In EXEC, ALU drive:
  - Opcodes 0–C: alu_opcode=req_opcode, alu_a=a, alu_b=b.
  - BIC: alu_opcode=0 (AND), alu_b=~b.
  - MVN: alu_opcode=1 (EOR), alu_a=32'hFFFFFFFF.
  - Outside EXEC all ALU outputs are 0.
- Condition pass, evaluated against flags_q during EXEC:
  - 0 Z; 1 ~Z; 2 C; 3 ~C; 4 N; 5 ~N; 6 V; 7 ~V.
  - 8 C&~Z; 9 ~C|Z; A N==V; B N!=V; C ~Z&(N==V); D Z|(N!=V).
  - E always; F never.
- executed = pass & (opcode!=F).
- rsp_we = executed & opcode not in {8,9,A,B}.
- rsp_result = executed ? alu_c : 0, captured at the end of EXEC.
- Flag update at the end of EXEC, when executed & (req_s | opcode in {8,9,A,B}):
  - Arithmetic (2–7, A, B): flags_q <= alu_flags.
  - Logical (0, 1, 8, 9, C, D, E): N and Z from alu_flags; C and V retained.
- flags_load writes flags_q in any state. If it coincides with an EXEC flag update, flags_load wins.
- Not executed: no flag change, rsp_we=0, rsp_executed=0, rsp_result=0.

## Timing
- Reset values: state IDLE, flags_q=0, rsp_valid=0, rsp_result=0, rsp_rd=0, rsp_we=0, rsp_executed=0, ALU outputs 0.
- req_ready=1 while reset is asserted and after release.
- Latency: a request accepted at edge N goes through EXEC in cycle N+1; rsp_valid is high from edge N+2.
- The flags_q update is visible from edge N+2.
- Throughput: one operation per 3 cycles minimum. No new request is accepted in EXEC or RESP.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs and flags_q (barring flags_load) are held stable.
- Condition evaluation uses flags_q as registered at the start of EXEC. A flags_load in the same cycle affects only later operations.
- Reset mid-EXEC or mid-RESP abandons the operation: no response, and flags return to 0.

## Test plan
- ADD, cond E, S=1, a=32'h7FFFFFFF, b=1 -> rsp_valid two cycles after accept, rsp_result=32'h80000000, rsp_we=1, flags_q=4'h9.
- CMP, cond E, S=0, a=5, b=5 -> rsp_we=0, rsp_executed=1, rsp_result=0, flags_q=4'h6.
- Following case 2, MVN cond 0 (EQ), b=0 -> rsp_result=32'hFFFFFFFF, rsp_we=1. Then ORR cond 1 (NE) -> rsp_executed=0, rsp_we=0, rsp_result=0, flags_q still 4'h6.
- flags_load 4'hC, then BIC, cond E, S=1, a=32'hFF, b=32'h0F -> rsp_result=32'hF0, flags_q=4'hC (C and V retained).
- ADD, S=1, with rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout. flags_load 4'h3 asserted in the EXEC cycle -> flags_q=4'h3. Release rsp_ready -> IDLE next cycle.
- Assert reset in the EXEC cycle of an ADD, S=1 -> rsp_valid never rises, flags_q=0, req_ready=1.
